lbm_step_sequencer: RTL

- Per-frame controller for the fluid update. Runs a programmable number of collide→stream steps per frame and owns the shared distribution BRAMs.
- Pulses the start inputs of the collision and streaming engines, waits on their done pulses and toggles the ping-pong bank after each step.
- Lends the BRAMs to the display reader only between frames.
- Sits between frame timing and the collision/streaming datapath, and drives the BRAM address/data mux select.

---
 rtl/lbm_step_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lbm_step_sequencer.sv
// Frame-level controller for the fluid update: runs N collide->stream steps per frame,
// flips the ping-pong bank after each step and lends the BRAMs to the display between frames.
module lbm_step_sequencer #(
  parameter int STEP_W    = 4,
  parameter int TIMEOUT   = 131072,
  parameter int TIMEOUT_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic [STEP_W-1:0] steps_in,
  input  logic              pause_in,
  input  logic              clear_err_in,
  output logic              collide_start_out,
  input  logic              collide_done_in,
  output logic              stream_start_out,
  input  logic              stream_done_in,
  output logic              bank_sel_out,
  output logic [1:0]        mem_owner_out,
  input  logic              display_req_in,
  input  logic              display_release_in,
  output logic              display_grant_out,
  output logic              busy_out,
  output logic [STEP_W-1:0] step_count_out,
  output logic              frame_done_out,
  output logic              frame_overrun_out,
  output logic              timeout_out
);

  typedef enum logic [2:0] {
    IDLE, C_START, C_WAIT, S_START, S_WAIT, STEP_END, DISPLAY, FAULT
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TIMER_MAX  = '1;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   target_q, target_d;
  logic [STEP_W-1:0]   step_count_q, step_count_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                bank_q, bank_d;
  logic                frame_pend_q, frame_pend_d;
  logic                disp_pend_q, disp_pend_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                collide_start_q, collide_start_d;
  logic                stream_start_q, stream_start_d;
  logic [1:0]          mem_owner_q, mem_owner_d;
  logic                grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    step_count_d = step_count_q;
    timer_d      = timer_q;
    bank_d       = bank_q;
    frame_pend_d = frame_pend_q;
    disp_pend_d  = disp_pend_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;

    // Any frame start outside IDLE/DISPLAY is dropped and flagged.
    if (frame_start_in && (state_q != IDLE) && (state_q != DISPLAY)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_pend_q) begin
          frame_pend_d = 1'b0;
          step_count_d = '0;
          overrun_d    = frame_start_in;
          disp_pend_d  = disp_pend_q | display_req_in;
          if (target_q == '0) frame_done_d = 1'b1;
          else                state_d      = C_START;
        end else if (frame_start_in) begin
          target_d     = steps_in;
          step_count_d = '0;
          disp_pend_d  = disp_pend_q | display_req_in;
          if (steps_in == '0) frame_done_d = 1'b1;
          else                state_d      = C_START;
        end else if (display_req_in || disp_pend_q) begin
          disp_pend_d = 1'b0;
          state_d     = DISPLAY;
        end
      end
      C_START: begin
        timer_d = '0;
        state_d = C_WAIT;
      end
      C_WAIT: begin
        if (collide_done_in)            state_d = S_START;
        else if (timer_q == TIMER_LAST) state_d = FAULT;
        else if (timer_q != TIMER_MAX)  timer_d = timer_q + TIMEOUT_W'(1);
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stream_done_in) begin
          state_d      = STEP_END;
          bank_d       = ~bank_q;
          step_count_d = step_count_q + STEP_W'(1);
        end else if (timer_q == TIMER_LAST) begin
          state_d = FAULT;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end
      STEP_END: begin
        if (step_count_q == target_q) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else if (!pause_in) begin
          state_d = C_START;
        end
      end
      DISPLAY: begin
        if (frame_start_in) begin
          if (frame_pend_q) begin
            overrun_d = 1'b1;
          end else begin
            frame_pend_d = 1'b1;
            target_d     = steps_in;
          end
        end
        if (display_release_in) state_d = IDLE;
      end
      FAULT: begin
        if (clear_err_in) begin
          state_d      = IDLE;
          step_count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    collide_start_d = (state_d == C_START);
    stream_start_d  = (state_d == S_START);
    grant_d         = (state_d == DISPLAY);
    timeout_d       = (state_d == FAULT);
    busy_d          = (state_d != IDLE) && (state_d != DISPLAY);
    mem_owner_d     = 2'd0;
    case (state_d)
      C_START, C_WAIT: mem_owner_d = 2'd1;
      S_START, S_WAIT: mem_owner_d = 2'd2;
      DISPLAY:         mem_owner_d = 2'd3;
      default:         mem_owner_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q         <= IDLE;
      target_q        <= '0;
      step_count_q    <= '0;
      timer_q         <= '0;
      bank_q          <= 1'b0;
      frame_pend_q    <= 1'b0;
      disp_pend_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
      collide_start_q <= 1'b0;
      stream_start_q  <= 1'b0;
      mem_owner_q     <= 2'd0;
      grant_q         <= 1'b0;
      busy_q          <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      step_count_q    <= step_count_d;
      timer_q         <= timer_d;
      bank_q          <= bank_d;
      frame_pend_q    <= frame_pend_d;
      disp_pend_q     <= disp_pend_d;
      frame_done_q    <= frame_done_d;
      overrun_q       <= overrun_d;
      collide_start_q <= collide_start_d;
      stream_start_q  <= stream_start_d;
      mem_owner_q     <= mem_owner_d;
      grant_q         <= grant_d;
      busy_q          <= busy_d;
      timeout_q       <= timeout_d;
    end
  end

  assign collide_start_out = collide_start_q;
  assign stream_start_out  = stream_start_q;
  assign bank_sel_out      = bank_q;
  assign mem_owner_out     = mem_owner_q;
  assign display_grant_out = grant_q;
  assign busy_out          = busy_q;
  assign step_count_out    = step_count_q;
  assign frame_done_out    = frame_done_q;
  assign frame_overrun_out = overrun_q;
  assign timeout_out       = timeout_q;

endmodule
